kulisch_accum_poc: RTL and testbench

- Downstream stage of the product shifter.
- Takes the shifted, sign-extended two's-complement product word (ACC_DESIRED bits) and sums it into a registered Kulisch accumulator, one term per accepted beat.
- Sums terms over a dot product framed by first/last flags, detects signed overflow, and hands the finished sum out through a one-entry valid/ready output register.
- Feeds its running sum back to the shifter's accumulator input port.

---
 rtl/kulisch_accum_poc.sv | 121 ++++++++++++
 tb/tb_kulisch_accum_poc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/kulisch_accum_poc.sv
// Kulisch accumulator stage: sums signed shifted products over a first/last framed
// dot product and presents each finished sum through a one-entry valid/ready register.
module kulisch_accum_poc #(
  parameter int ACC_DESIRED = 32,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_DESIRED-1:0] in_addend,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic [ACC_DESIRED-1:0] acc_q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_DESIRED-1:0] out_acc,
  output logic                   out_overflow,
  output logic [CNT_W-1:0]       out_count
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t                   state_q, state_d;
  logic [ACC_DESIRED-1:0]   acc_d;
  logic                     sticky_q, sticky_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [ACC_DESIRED-1:0]   out_acc_q, out_acc_d;
  logic                     out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]         out_cnt_q, out_cnt_d;

  logic                     accept;
  logic                     fresh;
  logic signed [ACC_DESIRED-1:0] base_s, addend_s, sum_s;
  logic                     ovf;
  logic                     sticky_nxt;
  logic [CNT_W-1:0]         cnt_nxt;

  assign out_valid    = out_valid_q;
  assign out_acc      = out_acc_q;
  assign out_overflow = out_ovf_q;
  assign out_count    = out_cnt_q;

  always_comb begin
    in_ready   = !out_valid_q || out_ready;
    accept     = in_valid && in_ready;
    // A first flag or an idle accumulator starts a fresh sum from zero.
    fresh      = in_first || (state_q == IDLE);
    addend_s   = in_addend;
    base_s     = fresh ? '0 : acc_q;
    sum_s      = base_s + addend_s;
    ovf        = add_ovf(base_s[ACC_DESIRED-1], addend_s[ACC_DESIRED-1], sum_s[ACC_DESIRED-1]);
    sticky_nxt = fresh ? ovf : (sticky_q | ovf);
    cnt_nxt    = fresh ? CNT_ONE : cnt_sat_inc(cnt_q);

    state_d     = state_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_ovf_d   = out_ovf_q;
    out_cnt_d   = out_cnt_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (in_last) begin
        // A new result may replace one being drained this same edge.
        out_valid_d = 1'b1;
        out_acc_d   = sum_s;
        out_ovf_d   = sticky_nxt;
        out_cnt_d   = cnt_nxt;
        acc_d       = '0;
        sticky_d    = 1'b0;
        cnt_d       = '0;
        state_d     = IDLE;
      end else begin
        acc_d    = sum_s;
        sticky_d = sticky_nxt;
        cnt_d    = cnt_nxt;
        state_d  = ACCUM;
      end
    end
  end

  // Single register stage: accumulator, frame state and output holding register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_ovf_q   <= out_ovf_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_kulisch_accum_poc.sv
// Directed scoreboard bench for kulisch_accum_poc: expected results are queued when
// the closing beat is driven and compared once the result register shows them.
module tb_kulisch_accum_poc;

  localparam int AW = 32;
  localparam int CW = 16;

  typedef struct {
    logic [AW-1:0] acc;
    logic          ovf;
    logic [CW-1:0] cnt;
  } result_t;

  logic          clock = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addend;
  logic          in_first;
  logic          in_last;
  logic [AW-1:0] acc_q;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic          out_overflow;
  logic [CW-1:0] out_count;

  result_t sb[$];
  int total = 0;
  int bad   = 0;

  kulisch_accum_poc #(.ACC_DESIRED(AW), .CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_addend(in_addend),
    .in_first(in_first), .in_last(in_last), .acc_q(acc_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_overflow(out_overflow), .out_count(out_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic o, input logic [CW-1:0] c);
    result_t r;
    r.acc = a;
    r.ovf = o;
    r.cnt = c;
    sb.push_back(r);
  endtask

  task automatic pop_check(input string tag);
    result_t r;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      r = sb.pop_front();
      chk({tag, "_acc"}, out_acc, r.acc);
      chk({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, r.ovf});
      chk({tag, "_cnt"}, {16'd0, out_count}, {16'd0, r.cnt});
    end
  endtask

  // Drive one beat, waiting (bounded) for in_ready, then release in_valid.
  task automatic drive(input logic [AW-1:0] a, input logic f, input logic l);
    int n;
    in_valid  = 1'b1;
    in_addend = a;
    in_first  = f;
    in_last   = l;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $error("FAIL drive_timeout observed=in_ready_low expected=in_ready_high");
    end
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_addend = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_acc", acc_q, 32'd0);
    chk("rst_oval", {31'd0, out_valid}, 32'd0);
    chk("rst_oacc", out_acc, 32'd0);
    chk("rst_ocnt", {16'd0, out_count}, 32'd0);
    chk("rst_oovf", {31'd0, out_overflow}, 32'd0);
    resetn = 1'b1;
    tick();

    // Reset in the middle of an open sum drops it without a result.
    drive(32'h10, 1'b1, 1'b0);
    drive(32'h40, 1'b0, 1'b0);
    chk("mid_acc", acc_q, 32'h50);
    resetn = 1'b0;
    tick();
    chk("midrst_acc", acc_q, 32'd0);
    chk("midrst_oval", {31'd0, out_valid}, 32'd0);
    chk("midrst_irdy", {31'd0, in_ready}, 32'd1);
    resetn = 1'b1;
    repeat (3) tick();
    chk("post_oval", {31'd0, out_valid}, 32'd0);
    chk("post_acc", acc_q, 32'd0);

    // Basic three-term sum with a negative term.
    drive(32'h10, 1'b1, 1'b0);
    drive(32'h20, 1'b0, 1'b0);
    push_exp(32'h20, 1'b0, 16'd3);
    drive(32'hFFFF_FFF0, 1'b0, 1'b1);
    pop_check("basic");
    chk("basic_accq", acc_q, 32'd0);
    tick();
    chk("basic_drain", {31'd0, out_valid}, 32'd0);
    chk("basic_hold", out_acc, 32'h20);

    // Signed overflow is sticky within a frame and cleared by the next frame.
    drive(32'h7FFF_FFFF, 1'b1, 1'b0);
    push_exp(32'h8000_0000, 1'b1, 16'd2);
    drive(32'h1, 1'b0, 1'b1);
    pop_check("ovf");
    push_exp(32'h1, 1'b0, 16'd1);
    drive(32'h1, 1'b1, 1'b1);
    pop_check("ovf_clr");
    tick();

    // Backpressure: pending result blocks input and stays stable.
    out_ready = 1'b0;
    push_exp(32'h9, 1'b0, 16'd1);
    drive(32'h9, 1'b1, 1'b1);
    pop_check("bp_res");
    in_valid  = 1'b1;
    in_addend = 32'h4;
    in_first  = 1'b1;
    in_last   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_irdy", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_oacc", out_acc, 32'h9);
      chk("bp_accq", acc_q, 32'd0);
      chk("bp_oval", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_irdy", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    chk("bp_accepted", acc_q, 32'h4);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    push_exp(32'hA, 1'b0, 16'd2);
    drive(32'h6, 1'b0, 1'b1);
    pop_check("bp_next");

    // Back-to-back single-term frames, one result per cycle.
    in_valid = 1'b1;
    in_first = 1'b1;
    in_last  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_addend = 32'(k);
      push_exp(32'(k), 1'b0, 16'd1);
      tick();
      pop_check("b2b");
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    tick();
    chk("b2b_end", {31'd0, out_valid}, 32'd0);

    // A first flag in the middle of a frame restarts the sum.
    drive(32'h5, 1'b1, 1'b0);
    drive(32'h7, 1'b0, 1'b0);
    chk("rs_partial", acc_q, 32'hC);
    push_exp(32'h3, 1'b0, 16'd1);
    drive(32'h3, 1'b1, 1'b1);
    pop_check("restart");
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
